// File: rtl/stream_pkt_arbiter.sv
// Per-packet N-channel byte-stream arbiter (round-robin or fixed priority) that
// splits packets at MAX_LEN and drives one registered output stage.
module stream_pkt_arbiter #(
    parameter  int NCH     = 4,
    parameter  int DW      = 8,
    parameter  int MAX_LEN = 512,
    parameter  int RR_MODE = 1,
    localparam int IDW     = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int CW      = $clog2(MAX_LEN + 1)
) (
    input  logic              hclk,
    input  logic              reset,
    input  logic [NCH-1:0]    ch_en,
    input  logic [NCH-1:0]    in_tvalid,
    output logic [NCH-1:0]    in_tready,
    input  logic [NCH*DW-1:0] in_tdata,
    input  logic [NCH-1:0]    in_tlast,
    output logic              out_tvalid,
    input  logic              out_tready,
    output logic [DW-1:0]     out_tdata,
    output logic              out_tlast,
    output logic [IDW-1:0]    out_tid,
    output logic [CW-1:0]     out_tcnt,
    output logic              busy
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] pick;
    logic           found;
    logic [CW-1:0]  len_q, len_d, len_nxt;
    logic [NCH-1:0] req;
    logic           sel_vld, sel_lst;
    logic [DW-1:0]  sel_dat;
    logic           ld, acc, split, last_beat;

    logic           out_tvalid_q, out_tvalid_d;
    logic           out_tlast_q, out_tlast_d;
    logic [DW-1:0]  out_tdata_q, out_tdata_d;
    logic [IDW-1:0] out_tid_q, out_tid_d;
    logic [CW-1:0]  out_tcnt_q, out_tcnt_d;

    assign req = in_tvalid & ch_en;

    // Round-robin scans rr_ptr..NCH-1 first, then wraps; fixed priority only runs the wrap scan.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        if (RR_MODE != 0) begin
            for (int c = 0; c < NCH; c++) begin
                if (!found && req[c] && (IDW'(c) >= rr_ptr_q)) begin
                    pick  = IDW'(c);
                    found = 1'b1;
                end
            end
        end
        for (int c = 0; c < NCH; c++) begin
            if (!found && req[c]) begin
                pick  = IDW'(c);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        sel_vld = 1'b0;
        sel_lst = 1'b0;
        sel_dat = '0;
        for (int c = 0; c < NCH; c++) begin
            if (grant_q == IDW'(c)) begin
                sel_vld = in_tvalid[c];
                sel_lst = in_tlast[c];
                sel_dat = in_tdata[c*DW +: DW];
            end
        end
    end

    assign ld        = !out_tvalid_q || out_tready;
    assign acc       = (state_q == BUSY) && ld && sel_vld;
    assign len_nxt   = len_q + CW'(1);
    assign split     = (len_nxt == CW'(MAX_LEN));
    assign last_beat = sel_lst || split;

    always_ff @(posedge hclk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req) state_d = BUSY;
            BUSY:    if (acc && last_beat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == BUSY);
        in_tready = '0;
        for (int c = 0; c < NCH; c++) begin
            in_tready[c] = (state_q == BUSY) && ld && (grant_q == IDW'(c));
        end
    end

    // A split ends the output packet exactly like a source tlast, so the tail re-arbitrates.
    always_comb begin
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        len_d        = len_q;
        out_tvalid_d = out_tvalid_q;
        out_tlast_d  = out_tlast_q;
        out_tdata_d  = out_tdata_q;
        out_tid_d    = out_tid_q;
        out_tcnt_d   = out_tcnt_q;
        if (state_q == IDLE && found) grant_d = pick;
        if (ld) out_tvalid_d = acc;
        if (acc) begin
            out_tdata_d = sel_dat;
            out_tlast_d = last_beat;
            out_tid_d   = grant_q;
            out_tcnt_d  = len_nxt;
            len_d       = last_beat ? '0 : len_nxt;
            if (last_beat)
                rr_ptr_d = (grant_q == IDW'(NCH - 1)) ? '0 : grant_q + IDW'(1);
        end
    end

    always_ff @(posedge hclk or posedge reset) begin
        if (reset) begin
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            len_q        <= '0;
            out_tvalid_q <= 1'b0;
            out_tlast_q  <= 1'b0;
            out_tdata_q  <= '0;
            out_tid_q    <= '0;
            out_tcnt_q   <= '0;
        end else begin
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            len_q        <= len_d;
            out_tvalid_q <= out_tvalid_d;
            out_tlast_q  <= out_tlast_d;
            out_tdata_q  <= out_tdata_d;
            out_tid_q    <= out_tid_d;
            out_tcnt_q   <= out_tcnt_d;
        end
    end

    assign out_tvalid = out_tvalid_q;
    assign out_tlast  = out_tlast_q;
    assign out_tdata  = out_tdata_q;
    assign out_tid    = out_tid_q;
    assign out_tcnt   = out_tcnt_q;

endmodule

// File: tb/tb_stream_pkt_arbiter.sv
// Bench for stream_pkt_arbiter: a round-robin and a fixed-priority instance
// (MAX_LEN=4) each fed from per-channel packet queues, checked beat by beat.
module tb_stream_pkt_arbiter;
    localparam int NCH = 4;
    localparam int ML  = 4;

    logic       hclk = 1'b0;
    logic       rst  = 1'b0;
    logic [3:0] en[2], tv[2], tr[2], tl[2];
    logic [31:0] td[2];
    logic       otv[2], otr[2], otl[2], bsy[2];
    logic [7:0] otd[2];
    logic [1:0] oid[2];
    logic [2:0] ocnt[2];

    always #5 hclk = ~hclk;

    stream_pkt_arbiter #(.NCH(NCH), .DW(8), .MAX_LEN(ML), .RR_MODE(1)) u_rr (
        .hclk(hclk), .reset(rst), .ch_en(en[0]), .in_tvalid(tv[0]), .in_tready(tr[0]),
        .in_tdata(td[0]), .in_tlast(tl[0]), .out_tvalid(otv[0]), .out_tready(otr[0]),
        .out_tdata(otd[0]), .out_tlast(otl[0]), .out_tid(oid[0]), .out_tcnt(ocnt[0]),
        .busy(bsy[0]));

    stream_pkt_arbiter #(.NCH(NCH), .DW(8), .MAX_LEN(ML), .RR_MODE(0)) u_fp (
        .hclk(hclk), .reset(rst), .ch_en(en[1]), .in_tvalid(tv[1]), .in_tready(tr[1]),
        .in_tdata(td[1]), .in_tlast(tl[1]), .out_tvalid(otv[1]), .out_tready(otr[1]),
        .out_tdata(otd[1]), .out_tlast(otl[1]), .out_tid(oid[1]), .out_tcnt(ocnt[1]),
        .busy(bsy[1]));

    int checks = 0, failures = 0;
    int cyc = 0, rmode = 0, nout = 0, hs_first = -1, hs_last = -1;
    bit gaps = 0;
    logic [8:0]  srcq[2][4][$];   // {last, data} per source beat
    logic [13:0] expq[2][$];      // {tid, tcnt, tlast, data}
    string       tids[2];
    logic [1:0]  mptr[2];
    logic        prev_stall[2];
    logic [13:0] prev_out[2];

    task automatic chk(string tag, int d, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s dut%0d obs=%0h exp=%0h", tag, d, obs, expv);
        end
    endtask

    task automatic chk_tids(int d, string expv);
        checks++;
        assert (tids[d] == expv) else begin
            failures++;
            $error("FAIL tids dut%0d obs=%s exp=%s", d, tids[d], expv);
        end
    endtask

    task automatic check_reset();
        for (int d = 0; d < 2; d++) begin
            chk("rst_out", d, {otv[d], otd[d], otl[d], oid[d], ocnt[d], bsy[d]}, 0);
            chk("rst_tready", d, tr[d], 0);
        end
    endtask

    // Same packet into both instances' sources.
    task automatic load(int c, int n);
        logic [8:0] b;
        for (int i = 0; i < n; i++) begin
            b = {(i == n - 1), 8'($urandom)};
            srcq[0][c].push_back(b);
            srcq[1][c].push_back(b);
        end
    endtask

    // Transaction-level reference: grant whole packets in arbitration order, cut at ML.
    task automatic build(int d);
        logic [8:0] cq[4][$];
        logic [8:0] b;
        logic [1:0] ix, g, ptr;
        bit got, lst;
        int len;
        tids[d] = "";
        for (int c = 0; c < 4; c++) cq[c] = srcq[d][c];
        ptr = mptr[d];
        for (int guard = 0; guard < 64; guard++) begin
            got = 0;
            g = 2'd0;
            for (int k = 0; k < 4; k++) begin
                ix = (d == 0) ? ptr + 2'(k) : 2'(k);
                if (!got && en[d][ix] && cq[ix].size() > 0) begin
                    got = 1;
                    g = ix;
                end
            end
            if (!got) break;
            len = 0;
            do begin
                b = cq[g].pop_front();
                len++;
                lst = b[8] || (len == ML);
                expq[d].push_back({g, 3'(len), lst, b[7:0]});
            end while (!lst && cq[g].size() > 0);
            ptr = g + 2'd1;
        end
        mptr[d] = ptr;
    endtask

    task automatic drive();
        logic [8:0] h;
        bit gap;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 4; c++) begin
                gap = gaps && tr[d][c] && ($urandom_range(3) == 0);
                if (srcq[d][c].size() > 0 && !gap) begin
                    h = srcq[d][c][0];
                    tv[d][c] = 1'b1;
                    tl[d][c] = h[8];
                    td[d][c*8 +: 8] = h[7:0];
                end else begin
                    tv[d][c] = 1'b0;
                    tl[d][c] = 1'b0;
                    td[d][c*8 +: 8] = 8'h00;
                end
            end
            case (rmode)
                0:       otr[d] = 1'b1;
                1:       otr[d] = ($urandom_range(1) != 0);
                default: otr[d] = (cyc % 4 == 0) || (cyc % 4 == 3);
            endcase
        end
    endtask

    // Entered just after a falling edge with inputs driven; returns after the next one.
    task automatic step();
        logic [3:0]  iacc[2];
        logic [13:0] sout[2];
        logic [14:0] e;
        #1;
        for (int d = 0; d < 2; d++) begin
            iacc[d] = tv[d] & tr[d];
            sout[d] = {oid[d], ocnt[d], otl[d], otd[d]};
            if (prev_stall[d]) chk("hold", d, {otv[d], sout[d]}, {1'b1, prev_out[d]});
            if (otv[d] && !otr[d]) chk("tready_while_stalled", d, tr[d], 0);
            chk("tready_onehot", d, ($countones(tr[d]) <= 1), 1);
            prev_stall[d] = otv[d] && !otr[d];
            prev_out[d]   = sout[d];
            if (otv[d] && otr[d]) begin
                if (expq[d].size() > 0) e = {1'b1, expq[d].pop_front()};
                else                    e = 15'h0;
                chk("out_beat", d, {1'b1, sout[d]}, e);
                if (sout[d][11:9] == 3'd1) tids[d] = $sformatf("%s%0d", tids[d], sout[d][13:12]);
                if (d == 0) begin
                    nout++;
                    if (hs_first < 0) hs_first = cyc;
                    hs_last = cyc;
                end
            end
        end
        @(posedge hclk);
        #1;
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 4; c++)
                if (iacc[d][c] && srcq[d][c].size() > 0) void'(srcq[d][c].pop_front());
        @(negedge hclk);
        cyc++;
        drive();
    endtask

    task automatic run_phase(string tag, int maxc);
        int n;
        n = 0;
        drive();
        while ((expq[0].size() > 0 || expq[1].size() > 0) && n < maxc) begin
            step();
            n++;
        end
        chk({tag, "_done"}, 0, expq[0].size() + expq[1].size(), 0);
        repeat (4) step();
        for (int d = 0; d < 2; d++) chk({tag, "_idle"}, d, {bsy[d], otv[d]}, 0);
    endtask

    initial begin
        int n;
        for (int d = 0; d < 2; d++) begin
            en[d] = 4'hF;
            mptr[d] = 2'd0;
            prev_stall[d] = 1'b0;
            prev_out[d] = '0;
            tids[d] = "";
        end
        drive();
        #1 rst = 1'b1;
        #1 check_reset();
        @(negedge hclk);
        @(negedge hclk);
        rst = 1'b0;
        drive();

        // Three requesters with ch0 re-requesting, pointer at 0.
        load(0, 2); load(0, 2); load(2, 2); load(3, 2);
        build(0); build(1);
        run_phase("t2", 200);
        chk_tids(0, "0230");
        chk_tids(1, "0023");

        // Single 3-beat packet on ch1; mask dropped mid-packet must not cut it.
        for (int d = 0; d < 2; d++) en[d] = 4'b0010;
        load(1, 3);
        build(0); build(1);
        hs_first = -1;
        drive();
        repeat (3) step();
        for (int d = 0; d < 2; d++) en[d] = 4'b0000;
        run_phase("t1", 100);
        chk("t1_consec", 0, hs_last - hs_first, 2);
        chk_tids(0, "1");
        chk_tids(1, "1");
        for (int d = 0; d < 2; d++) en[d] = 4'hF;

        // ch0 keeps requesting against ch3, random output backpressure.
        rmode = 1;
        load(0, 2); load(0, 2); load(0, 2); load(3, 3);
        build(0); build(1);
        run_phase("t3", 300);
        chk_tids(0, "3000");
        chk_tids(1, "0003");

        // 6-beat packet split at 4, competing with ch3.
        rmode = 0;
        load(2, 6); load(3, 2);
        build(0); build(1);
        run_phase("t4", 200);
        chk_tids(0, "232");
        chk_tids(1, "223");

        // Output ready pattern 1,0,0,1.
        rmode = 2;
        load(0, 5); load(2, 3);
        build(0); build(1);
        run_phase("t5", 300);

        // Reset in the middle of a 5-beat ch1 packet with the pointer parked at 3.
        rmode = 0;
        load(2, 1);
        build(0); build(1);
        run_phase("t6_pre", 100);
        load(1, 5);
        build(0); build(1);
        nout = 0;
        n = 0;
        drive();
        while (nout < 2 && n < 50) begin
            step();
            n++;
        end
        chk("t6_reach", 0, nout, 2);
        #2 rst = 1'b1;
        #1 check_reset();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 4; c++) srcq[d][c].delete();
            expq[d].delete();
            tids[d] = "";
            prev_stall[d] = 1'b0;
            mptr[d] = 2'd0;
        end
        drive();
        @(posedge hclk);
        @(negedge hclk);
        rst = 1'b0;
        load(1, 5); load(3, 2);
        build(0); build(1);
        run_phase("t6", 200);
        chk_tids(0, "131");
        chk_tids(1, "113");

        // Random packets, random masks, random backpressure and mid-packet source gaps.
        rmode = 1;
        gaps = 1;
        for (int r = 0; r < 6; r++) begin
            en[0] = 4'($urandom);
            en[1] = en[0];
            for (int c = 0; c < 4; c++)
                for (int p = 0; p < int'($urandom_range(2)); p++) load(c, int'($urandom_range(1, 9)));
            build(0); build(1);
            run_phase("rand", 800);
            en[0] = 4'hF;
            en[1] = 4'hF;
            build(0); build(1);
            run_phase("rand_rest", 800);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
